cmd_frame_parser: RTL

- Front-end command stage of the MxV datapath; sits directly upstream of the command counter.
- Consumes the received byte stream from the serial receiver and delineates frames of the form START, LEN, CMD, payload, END.
- Streams payload bytes to the datapath and reports the command code.
- Per validated frame, pulses the counter enable; per malformed or timed-out frame, pulses the counter clear.

---
 rtl/mxv_pkg.sv | 33 +++
 rtl/frame_timeout_counter.sv | 42 ++++
 rtl/cmd_frame_parser.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mxv_pkg.sv
// Shared types and constants for the MxV command front end.
// Used by the frame parser and the serial-side helper stages.
package mxv_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    CMD,
    PAYLOAD,
    END
  } parser_state_t;

  localparam byte_t START_BYTE_C = 8'hFE;
  localparam byte_t END_BYTE_C = 8'hEF;

  localparam int unsigned MAX_LEN_C = 16;
  localparam int unsigned TIMEOUT_CYC_C = 1024;

  localparam byte_t CMD_SET_N = 8'h01;
  localparam byte_t CMD_START = 8'h03;
  localparam byte_t CMD_LOAD = 8'h04;

  // A LEN byte counts CMD plus payload, so zero is never legal.
  function automatic logic len_ok(
    input byte_t len,
    input byte_t max_len
  );
    return (len != 8'h00) && (len <= max_len);
  endfunction

endpackage

// File: rtl/frame_timeout_counter.sv
// Idle-cycle watchdog for byte-oriented serial stages.
// Pulses expired_o on the TIMEOUT_CYC-th idle cycle while enabled.
module frame_timeout_counter #(
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W =
    (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Expiry depends only on the count, so a byte
  // landing on the same cycle cannot mask it.
  assign expired_o = enable_i && (cnt_q == LAST);

  // Next count: restart on a byte, when idle, or on expiry.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || !enable_i || expired_o) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_frame_parser.sv
// Frame delineation for START, LEN, CMD, payload, END command frames.
// Streams payload, reports the command and drives counter enable/clear.
module cmd_frame_parser
  import mxv_pkg::*;
#(
  parameter byte_t       START_BYTE  = START_BYTE_C,
  parameter byte_t       END_BYTE    = END_BYTE_C,
  parameter int unsigned MAX_LEN     = MAX_LEN_C,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_C
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  output logic [7:0]                 o_cmd,
  output logic [7:0]                 o_data,
  output logic                       o_data_valid,
  output logic [$clog2(MAX_LEN)-1:0] o_data_idx,
  output logic                       o_cmd_done,
  output logic                       o_cnt_ena,
  output logic                       o_cnt_clear,
  output logic                       o_err,
  output logic                       o_busy
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam byte_t MAX_LEN_B = byte_t'(MAX_LEN);

  parser_state_t    state_q;
  logic [LEN_W-1:0] rem_q;
  logic [IDX_W-1:0] idx_cnt_q;
  logic [IDX_W-1:0] idx_q;
  byte_t            cmd_q;
  byte_t            data_q;
  logic             dv_q;
  logic             done_q;
  logic             ena_q;
  logic             clr_q;
  logic             err_q;
  logic             busy_q;

  logic tmo_en;
  logic tmo_expired;

  assign tmo_en = (state_q != IDLE);

  frame_timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk_i    (clk),
    .rst_ni   (rst),
    .clear_i  (i_rx_valid),
    .enable_i (tmo_en),
    .expired_o(tmo_expired)
  );

  // Frame FSM with registered strobes; an aborted
  // frame returns straight to IDLE, so an offending
  // START byte never opens a new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      idx_cnt_q <= '0;
      idx_q     <= '0;
      cmd_q     <= '0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
      ena_q     <= 1'b0;
      clr_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      dv_q   <= 1'b0;
      done_q <= 1'b0;
      ena_q  <= 1'b0;
      clr_q  <= 1'b0;
      err_q  <= 1'b0;
      if (tmo_expired) begin
        err_q   <= 1'b1;
        clr_q   <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= IDLE;
      end else if (i_rx_valid) begin
        unique case (state_q)
          IDLE: begin
            if (i_rx_data == START_BYTE) begin
              busy_q  <= 1'b1;
              state_q <= LEN;
            end
          end
          LEN: begin
            if (len_ok(i_rx_data, MAX_LEN_B)) begin
              rem_q   <= i_rx_data[LEN_W-1:0];
              state_q <= CMD;
            end else begin
              err_q   <= 1'b1;
              clr_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          CMD: begin
            cmd_q     <= i_rx_data;
            idx_cnt_q <= '0;
            idx_q     <= '0;
            rem_q     <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= END;
            end else begin
              state_q <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            data_q    <= i_rx_data;
            dv_q      <= 1'b1;
            idx_q     <= idx_cnt_q;
            idx_cnt_q <= idx_cnt_q + IDX_W'(1);
            rem_q     <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= END;
            end
          end
          END: begin
            if (i_rx_data == END_BYTE) begin
              done_q <= 1'b1;
              ena_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
              clr_q <= 1'b1;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign o_cmd        = cmd_q;
  assign o_data       = data_q;
  assign o_data_valid = dv_q;
  assign o_data_idx   = idx_q;
  assign o_cmd_done   = done_q;
  assign o_cnt_ena    = ena_q;
  assign o_cnt_clear  = clr_q;
  assign o_err        = err_q;
  assign o_busy       = busy_q;

endmodule
